// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and constants for the Gray counter slice.
// Functions operate on the widest supported word; callers zero-extend
// narrower values and keep only the low bits of the result.
package gray_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 4;
    localparam int GRAY_WIDTH_MAX     = 16;

    typedef logic [GRAY_WIDTH_MAX-1:0] gray_word_t;

    // Action taken by the counter on a given clock edge.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'b00,
        STEP_LOAD = 2'b01,
        STEP_UP   = 2'b10,
        STEP_DOWN = 2'b11
    } step_kind_e;

    // Binary to reflected Gray code.
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code back to binary (prefix XOR from the MSB down).
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_WIDTH_MAX-1] = g[GRAY_WIDTH_MAX-1];
        for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray encoder, WIDTH bits wide.
// Sits in front of the gray output register so bin and gray are
// captured from the same next-state value on the same edge.
module bin_to_gray
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    gray_word_t bin_ext_s;
    gray_word_t gray_ext_s;

    // Zero-extend the input to the helper's word width.
    always_comb begin
        bin_ext_s              = 16'h0000;
        bin_ext_s[WIDTH-1:0]   = bin;
    end

    assign gray_ext_s = bin2gray(bin_ext_s);
    assign gray       = gray_ext_s[WIDTH-1:0];

    // Upper bits of the encoded word are always zero for a zero-extended
    // input; they are deliberately dropped.
    generate
        if (WIDTH < GRAY_WIDTH_MAX) begin : g_pad
            logic unused_hi_s;
            assign unused_hi_s = ^gray_ext_s[GRAY_WIDTH_MAX-1:WIDTH];
        end
    endgenerate

endmodule

// File: rtl/gray_counter.sv
// Gray counter with synchronous load and registered binary, Gray and wrap
// outputs. The binary count is the state; the Gray output is encoded from
// the next binary value so both outputs come from one register update.
// Optional build macro GRAY_CNT_UPDOWN_EN adds the 'up' direction input
// and the down-count path; without it the counter counts up only.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
`ifdef GRAY_CNT_UPDOWN_EN
    input  logic             up,
`endif
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             up_s;
    step_kind_e       step_s;
    logic [WIDTH-1:0] bin_next_s;
    logic [WIDTH-1:0] gray_next_s;
    logic             wrap_next_s;

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;

`ifdef GRAY_CNT_UPDOWN_EN
    assign up_s = up;
`else
    assign up_s = 1'b1;
`endif

    // Classify the action for this edge; load outranks en and direction.
    always_comb begin
        step_s = STEP_HOLD;
        if (load) begin
            step_s = STEP_LOAD;
        end else if (en) begin
            if (up_s) begin
                step_s = STEP_UP;
            end else begin
                step_s = STEP_DOWN;
            end
        end else begin
            step_s = STEP_HOLD;
        end
    end

    // Next binary count and wrap pulse; wrap only ever comes from an en step.
    always_comb begin
        bin_next_s  = bin_r;
        wrap_next_s = 1'b0;
        case (step_s)
            STEP_LOAD: begin
                bin_next_s  = load_bin;
                wrap_next_s = 1'b0;
            end
            STEP_UP: begin
                bin_next_s  = bin_r + ONE_C;
                wrap_next_s = (bin_r == MAX_C);
            end
            STEP_DOWN: begin
                bin_next_s  = bin_r - ONE_C;
                wrap_next_s = (bin_r == ZERO_C);
            end
            STEP_HOLD: begin
                bin_next_s  = bin_r;
                wrap_next_s = 1'b0;
            end
            default: begin
                bin_next_s  = bin_r;
                wrap_next_s = 1'b0;
            end
        endcase
    end

    bin_to_gray #(
        .WIDTH (WIDTH)
    ) u_bin_to_gray (
        .bin  (bin_next_s),
        .gray (gray_next_s)
    );

    // Output registers; reset clears everything with no clock required.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r  <= ZERO_C;
            gray_r <= ZERO_C;
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= bin_next_s;
            gray_r <= gray_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign bin  = bin_r;
    assign gray = gray_r;
    assign wrap = wrap_r;

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: en  input  1  advance count by one step when high.
REQ-005 SHALL have port: load  input  1  synchronous load of load_bin when high.
REQ-006 SHALL have port: load_bin  input  WIDTH  binary value to load.
REQ-007 SHALL have port: up  input  1  direction, 1 = increment, 0 = decrement (present only with GRAY_CNT_UPDOWN_EN).
REQ-008 SHALL have port: gray  output  WIDTH  registered Gray-coded count.
REQ-009 SHALL have port: bin  output  WIDTH  registered binary count, cycle-aligned with gray.
REQ-010 SHALL have port: wrap  output  1  registered one-cycle pulse on count wrap-around.

Function
REQ-011 SHALL hold the binary count internally and present gray = bin ^ (bin >> 1) from the same register state, with no cycle skew between bin and gray.
REQ-012 SHALL update outputs exactly one clk edge after the sampling edge for load or en (latency 1).
REQ-013 SHALL give load priority over en: if load=1, bin <= load_bin regardless of en or up.
REQ-014 SHALL, when load=0 and en=1, step bin by +1 (up) or -1 (down), modulo 2^WIDTH.
REQ-015 SHALL hold bin, gray unchanged when load=0 and en=0, and drive wrap=0.
REQ-016 SHALL assert wrap for exactly one cycle when an en step moves bin from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down).
REQ-017 SHALL NOT assert wrap on a load, including a load of 0 or 2^WIDTH-1.
REQ-018 SHALL change exactly one bit of gray on every en step, including the wrap step.
REQ-019 SHALL accept en held high for consecutive cycles, stepping once per cycle with no bubbles.
REQ-020 SHALL treat up as sampled on the same edge as en; a direction change takes effect on that step.

Reset
REQ-021 SHALL, on rst_n low, immediately (asynchronously) force bin=0, gray=0, wrap=0.
REQ-022 SHALL abandon any in-progress step or load when reset asserts mid-operation; no pending state survives reset.
REQ-023 SHALL resume counting on the first rising clk edge with rst_n high and en or load high.

Configuration
REQ-024 SHALL compile the up input and down-count path only when macro GRAY_CNT_UPDOWN_EN is defined.
REQ-025 SHALL, without GRAY_CNT_UPDOWN_EN, omit the up port and count up only; wrap then fires only on max->0.

Structure
REQ-026 SHALL take from shared package gray_pkg: functions bin2gray and gray2bin, constant GRAY_WIDTH_DEFAULT = 4.
REQ-027 SHALL instantiate one combinational sub-module bin_to_gray (WIDTH-parameterised) for the output encode, placed before the gray register.
REQ-028 SHALL keep gray2bin(gray) == bin as an invariant checked by the bench.

Verification (WIDTH=4)
REQ-029 SHALL verify reset: rst_n=0 mid-count at bin=6 -> bin=0, gray=0000, wrap=0 without a clock edge.
REQ-030 SHALL verify up-count: en=1 for 16 cycles from 0 -> gray sequence 0000,0001,0011,0010,0110,...,1000 then 0000; wrap=1 only on the 15->0 step; one bit changes per step.
REQ-031 SHALL verify load priority: load=1, en=1, load_bin=1011 -> bin=1011, gray=1110 next cycle, wrap=0.
REQ-032 SHALL verify down wrap (macro on): bin=0, up=0, en=1 -> bin=1111, gray=1000, wrap=1 for one cycle.
REQ-033 SHALL verify hold: en=0, load=0 for 5 cycles at bin=0101 -> gray stays 0111, wrap=0.
REQ-034 SHALL verify load of 1111 then en step up -> bin=0000, wrap=1 on the step only, not on the load.
